// File: rtl/delay_capture_pkg.sv
// Shared constants for the delay_capture block: FSM encoding, default counter width
// and the input pipeline depth selected by the SYNC_INPUTS_EN build macro.
package delay_capture_pkg;

    localparam int DEFAULT_COUNTER_SIZE = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Extra cycles an input spends in the synchronizer before reaching edge detect.
`ifdef SYNC_INPUTS_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 0;
`endif

endpackage

// File: rtl/delay_capture_if.sv
// Bundle of the timer-side event inputs and the measurement result outputs.
// The master side raises start/stop; the slave side (delay_capture) reports results.
interface delay_capture_if
    import delay_capture_pkg::*;
#(
    parameter int COUNTER_SIZE = DEFAULT_COUNTER_SIZE
);

    logic                    start;
    logic                    stop;
    logic                    busy;
    logic                    meas_valid;
    logic                    meas_timeout;
    logic [COUNTER_SIZE-1:0] meas_count;

    // Handshake: there is no ready. meas_valid is a single-cycle strobe that the consumer
    // must take when it sees it; meas_count/meas_timeout stay stable until the next strobe.
    modport master (
        output start,
        output stop,
        input  busy,
        input  meas_valid,
        input  meas_timeout,
        input  meas_count
    );

    modport slave (
        input  start,
        input  stop,
        output busy,
        output meas_valid,
        output meas_timeout,
        output meas_count
    );

endinterface

// File: rtl/delay_capture_rise_detect.sv
// Level-to-pulse converter: optional 2-flop synchronizer (SYNC_INPUTS_EN) then a history
// flop; rise is a one-cycle pulse on each low-to-high transition of the sampled level.
module delay_capture_rise_detect
    import delay_capture_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    localparam int ARM_DEPTH = SYNC_STAGES + 1;

    logic                 sampled;
    logic                 hist_q;
    logic [ARM_DEPTH-1:0] arm_q;

`ifdef SYNC_INPUTS_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], level};
        end
    end

    assign sampled = sync_q[1];
`else
    assign sampled = level;
`endif

    // arm_q fills with ones once the history flop holds a genuine post-reset sample, so a
    // level already high when reset is released is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            hist_q <= sampled;
            arm_q  <= (arm_q << 1) | ARM_DEPTH'(1);
        end
    end

    assign rise = sampled & ~hist_q & arm_q[ARM_DEPTH-1];

endmodule

// File: rtl/delay_capture.sv
// Measures clk cycles from a start rising edge to the next stop rising edge, with timeout
// at MAX_COUNT. Build macro SYNC_INPUTS_EN adds 2-flop input synchronizers.
module delay_capture
    import delay_capture_pkg::*;
#(
    parameter int COUNTER_SIZE = DEFAULT_COUNTER_SIZE,
    parameter int MAX_COUNT    = 2**COUNTER_SIZE - 1
)(
    input  logic           clk,
    input  logic           rst_n,
    delay_capture_if.slave bus,
    output state_t         dbg_state
);

    localparam logic [COUNTER_SIZE-1:0] MAX_C = COUNTER_SIZE'(MAX_COUNT);
    localparam logic [COUNTER_SIZE-1:0] ONE_C = COUNTER_SIZE'(1);

    logic                    start_rise;
    logic                    stop_rise;
    state_t                  state;
    logic [COUNTER_SIZE-1:0] cnt;
    logic [COUNTER_SIZE-1:0] cnt_inc;
    logic                    busy_q;
    logic                    valid_q;
    logic                    timeout_q;
    logic [COUNTER_SIZE-1:0] count_q;

    delay_capture_rise_detect u_start_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bus.start),
        .rise  (start_rise)
    );

    delay_capture_rise_detect u_stop_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bus.stop),
        .rise  (stop_rise)
    );

    // cnt stays below MAX_COUNT while counting, so the increment cannot wrap.
    assign cnt_inc = cnt + ONE_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state  <= COUNT;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                COUNT: begin
                    cnt <= cnt_inc;
                    // A stop edge landing on the limit cycle still counts as a real stop.
                    if (stop_rise) begin
                        count_q   <= cnt_inc;
                        timeout_q <= 1'b0;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end else if (cnt_inc == MAX_C) begin
                        count_q   <= MAX_C;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.meas_valid   = valid_q;
    assign bus.meas_timeout = timeout_q;
    assign bus.meas_count   = count_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_delay_capture.sv
// Bench for delay_capture: directed scenarios plus randomized intervals and toggling,
// checked every cycle against a timestamp-based reference model.
module tb_delay_capture;
    import delay_capture_pkg::*;

    localparam int CS  = 16;
    localparam int MAX = 100;
`ifdef SYNC_INPUTS_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    delay_capture_if #(.COUNTER_SIZE(CS)) bus ();

    delay_capture #(
        .COUNTER_SIZE (CS),
        .MAX_COUNT    (MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // Input levels are logged per edge since reset; an event is a 0->1 step in the
    // (optionally D-edge delayed) log, and the interval is the edge-count difference.
    bit            start_log[$];
    bit            stop_log[$];
    logic          m_busy, m_valid, m_timeout;
    logic [CS-1:0] m_count;
    int            t0, n, i;
    bit            s_r, p_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_log.delete();
            stop_log.delete();
            m_busy    = 1'b0;
            m_valid   = 1'b0;
            m_timeout = 1'b0;
            m_count   = '0;
            t0        = 0;
        end else begin
            cyc++;
            start_log.push_back(bus.start);
            stop_log.push_back(bus.stop);
            n   = start_log.size();
            i   = n - 1 - D;
            s_r = (i >= 1) && start_log[i] && !start_log[i-1];
            p_r = (i >= 1) && stop_log[i] && !stop_log[i-1];
            m_valid = 1'b0;
            if (!m_busy) begin
                if (s_r) begin
                    m_busy = 1'b1;
                    t0     = n;
                end
            end else if (p_r) begin
                m_busy = 1'b0; m_valid = 1'b1; m_timeout = 1'b0; m_count = CS'(n - t0);
            end else if (n - t0 == MAX) begin
                m_busy = 1'b0; m_valid = 1'b1; m_timeout = 1'b1; m_count = CS'(MAX);
            end
        end
    end

    // ---------------- per-cycle scoreboard and window statistics ----------------
    int            valid_pulses, busy_cycles, last_valid_cyc;
    logic [CS-1:0] last_count;
    logic          last_to;

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("meas_valid", 32'(bus.meas_valid), 32'(m_valid));
            check("meas_count", 32'(bus.meas_count), 32'(m_count));
            check("meas_timeout", 32'(bus.meas_timeout), 32'(m_timeout));
            if (bus.meas_valid) begin
                valid_pulses++;
                last_valid_cyc = cyc;
                last_count     = bus.meas_count;
                last_to        = bus.meas_timeout;
            end
            if (bus.busy) busy_cycles++;
        end
    end

    task automatic clear_stats();
        valid_pulses   = 0;
        busy_cycles    = 0;
        last_valid_cyc = 0;
        last_count     = '0;
        last_to        = 1'b0;
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        step(3 + D);
    endtask

    task automatic measure(input int interval);
        bus.start = 1'b1;
        step(interval);
        bus.stop = 1'b1;
        step(2 + D);
        idle_inputs();
    endtask

    int stop_cyc;
    int ivl;

    initial begin
        clear_stats();
        // 1: reset with inputs high, release with inputs still high
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        rst_n     = 1'b0;
        step(3);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_valid", 32'(bus.meas_valid), 0);
        check("rst_count", 32'(bus.meas_count), 0);
        check("rst_timeout", 32'(bus.meas_timeout), 0);
        rst_n = 1'b1;
        step(8);
        check("rel_pulses", 32'(valid_pulses), 0);
        check("rel_busy_cycles", 32'(busy_cycles), 0);
        idle_inputs();

        // 2: nominal 31-cycle interval
        clear_stats();
        bus.start = 1'b1;
        step(31);
        bus.stop = 1'b1;
        stop_cyc = cyc;
        step(3 + D);
        idle_inputs();
        check("nom_pulses", 32'(valid_pulses), 1);
        check("nom_count", 32'(last_count), 31);
        check("nom_timeout", 32'(last_to), 0);
        check("nom_busy_cycles", 32'(busy_cycles), 31);
        check("nom_latency", 32'(last_valid_cyc - stop_cyc), 32'(1 + D));

        // 3: minimum interval with stop held high
        clear_stats();
        bus.start = 1'b1;
        step(1);
        bus.stop = 1'b1;
        step(3);
        bus.stop = 1'b0;
        step(4 + D);
        idle_inputs();
        check("min_pulses", 32'(valid_pulses), 1);
        check("min_count", 32'(last_count), 1);

        // 4: timeout, then a late stop edge
        clear_stats();
        bus.start = 1'b1;
        step(2);
        bus.start = 1'b0;
        step(MAX + 5 + D);
        check("to_pulses", 32'(valid_pulses), 1);
        check("to_timeout", 32'(last_to), 1);
        check("to_count", 32'(last_count), 32'(MAX));
        check("to_busy", 32'(bus.busy), 0);
        check("to_busy_cycles", 32'(busy_cycles), 32'(MAX));
        clear_stats();
        bus.stop = 1'b1;
        step(3 + D);
        idle_inputs();
        check("late_stop_pulses", 32'(valid_pulses), 0);

        // 5a: start and stop rise together
        clear_stats();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step(1);
        bus.stop = 1'b0;
        step(19);
        bus.stop = 1'b1;
        step(2 + D);
        idle_inputs();
        check("same_cyc_pulses", 32'(valid_pulses), 1);
        check("same_cyc_count", 32'(last_count), 20);

        // 5b: start re-pulsed mid-measurement
        clear_stats();
        bus.start = 1'b1;
        step(5);
        bus.start = 1'b0;
        step(5);
        bus.start = 1'b1;
        step(30);
        bus.stop = 1'b1;
        step(2 + D);
        idle_inputs();
        check("restart_pulses", 32'(valid_pulses), 1);
        check("restart_count", 32'(last_count), 40);

        // 5c: stop on the limit cycle
        clear_stats();
        measure(MAX);
        check("limit_pulses", 32'(valid_pulses), 1);
        check("limit_count", 32'(last_count), 32'(MAX));
        check("limit_timeout", 32'(last_to), 0);

        // 6: reset mid-measurement
        clear_stats();
        bus.start = 1'b1;
        step(11 + D);
        check("mid_busy_before", 32'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #2;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_count", 32'(bus.meas_count), 0);
        check("mid_rst_valid", 32'(bus.meas_valid), 0);
        step(2);
        rst_n = 1'b1;
        step(20);
        idle_inputs();
        check("mid_pulses", 32'(valid_pulses), 0);
        check("mid_count_after", 32'(bus.meas_count), 0);

        // Randomized intervals, including some beyond the timeout limit
        for (int r = 0; r < 10; r++) begin
            clear_stats();
            ivl = $urandom_range(1, MAX + 20);
            measure(ivl);
            check("rnd_pulses", 32'(valid_pulses), 1);
            check("rnd_count", 32'(last_count), 32'((ivl >= MAX) ? MAX : ivl));
            check("rnd_timeout", 32'(last_to), 32'(ivl > MAX));
        end

        // Random level toggling with occasional asynchronous reset
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0) bus.start = ~bus.start;
            if ($urandom_range(0, 13) == 0) bus.stop = ~bus.stop;
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step(1);
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
